// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one outstanding imem request, DEPTH-entry queue to the decoder.
// Optional FETCH_BYPASS_EN: an ack into an empty queue is presented to the decoder in the same cycle.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DISCARD = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              halt_pend_q, halt_pend_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] old_addr_q, old_addr_d;
  logic              req_en_q;
  logic              flush, push, acked, byp, q_valid, q_pop;

  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]       mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];

  // imem: req is held with addr stable until a one-cycle ack; an ack without req is ignored.
  // Decoder side: a word transfers on every cycle with instr_valid & instr_ready.
  assign imem_req  = req_en_q &
                     (((state_q == S_RUN) && (cnt_q != CNT_W'(DEPTH))) || (state_q == S_DISCARD));
  assign imem_addr = (state_q == S_DISCARD) ? old_addr_q : pc_q;
  assign acked     = imem_ack & imem_req;
  assign q_valid   = (cnt_q != '0) && (state_q != S_HALTED);
  assign halted    = (state_q == S_HALTED);
  assign dbg_state = state_q;

`ifdef FETCH_BYPASS_EN
  assign byp         = (state_q == S_RUN) && (cnt_q == '0) && acked && !redirect && !halt;
  assign instr_valid = q_valid | byp;
  assign instr       = byp ? imem_rdata : (q_valid ? mem_data[rd_ptr_q] : '0);
  assign instr_pc    = byp ? pc_q : (q_valid ? mem_pc[rd_ptr_q] : '0);
`else
  assign byp         = 1'b0;
  assign instr_valid = q_valid;
  assign instr       = q_valid ? mem_data[rd_ptr_q] : '0;
  assign instr_pc    = q_valid ? mem_pc[rd_ptr_q] : '0;
`endif

  // A bypassed word never enters the queue, so only queued words pop it.
  assign q_pop = q_valid & instr_ready & ~byp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      halt_pend_q <= 1'b0;
      pc_q        <= RESET_PC;
      old_addr_q  <= RESET_PC;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      pc_q        <= pc_d;
      old_addr_q  <= old_addr_d;
      req_en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    pc_d        = pc_q;
    old_addr_d  = old_addr_q;
    flush       = 1'b0;
    push        = 1'b0;
    case (state_q)
      S_RUN: begin
        if (halt) begin
          flush = 1'b1;
          if (imem_req && !imem_ack) begin
            state_d     = S_DISCARD;
            halt_pend_d = 1'b1;
            old_addr_d  = pc_q;
          end else begin
            state_d = S_HALTED;
          end
        end else if (redirect) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
          if (imem_req && !imem_ack) begin
            state_d    = S_DISCARD;
            old_addr_d = pc_q;
          end
        end else if (acked) begin
          pc_d = pc_q + ADDR_W'(1);
          push = !(byp && instr_ready);
        end
      end
      S_DISCARD: begin
        // Old request must still complete; its data is thrown away.
        if (halt) halt_pend_d = 1'b1;
        else if (redirect && !halt_pend_q) pc_d = redirect_pc;
        if (acked) state_d = (halt || halt_pend_q) ? S_HALTED : S_RUN;
      end
      S_HALTED: ;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (q_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !q_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!push && q_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]   <= pc_q;
    end
  end

endmodule
